// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MIPS opcode/function constants, the issue-queue
// entry layout and the predecode record consumed by the dual-issue pairing logic.
package pipeline_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2a;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_SWR     = 6'h2e;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_BREAK   = 6'h0d;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;
  localparam logic [5:0] FN_ADDU    = 6'h21;

  // REGIMM rt selectors
  localparam logic [4:0] BLTZ       = 5'h00;
  localparam logic [4:0] BGEZ       = 5'h01;
  localparam logic [4:0] BLTZAL     = 5'h10;
  localparam logic [4:0] BGEZAL     = 5'h11;

  // COP0 rs selectors
  localparam logic [4:0] COP0_MF    = 5'h00;
  localparam logic [4:0] COP0_MT    = 5'h04;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } iq_entry_t;

  typedef struct packed {
    logic       is_branch;
    logic       is_mem;
    logic       is_serial;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [4:0] dst;
  } predecode_t;

endpackage

// File: rtl/instr_predecode.sv
// Combinational predecoder: classifies one instruction word for the pairing
// rules (branch, memory, serialising) and extracts its register sources/dest.
module instr_predecode
  import pipeline_pkg::*;
(
  input  logic [31:0] instr,
  output predecode_t  pd
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign fn = instr[5:0];

  // Opcode-class decode; sources mirror the decode stage's register-read selection
  always_comb begin
    pd = '0;
    case (op)
      OP_SPECIAL: begin
        pd.dst  = rd;
        pd.src1 = rs;
        pd.src2 = rt;
        case (fn)
          FN_SLL, FN_SRL, FN_SRA: pd.src1 = 5'd0;
          FN_JR, FN_JALR:         pd.is_branch = 1'b1;
          FN_SYSCALL, FN_BREAK, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: pd.is_serial = 1'b1;
          default: ;
        endcase
      end
      OP_REGIMM: begin
        pd.src1 = rs;
        if (rt == BLTZ || rt == BGEZ || rt == BLTZAL || rt == BGEZAL)
          pd.is_branch = 1'b1;
        if (rt == BLTZAL || rt == BGEZAL)
          pd.dst = 5'd31;
      end
      OP_J: pd.is_branch = 1'b1;
      OP_JAL: begin
        pd.is_branch = 1'b1;
        pd.dst       = 5'd31;
      end
      OP_BEQ, OP_BNE: begin
        pd.is_branch = 1'b1;
        pd.src1      = rs;
        pd.src2      = rt;
      end
      OP_BLEZ, OP_BGTZ: begin
        pd.is_branch = 1'b1;
        pd.src1      = rs;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        pd.src1 = rs;
        pd.dst  = rt;
      end
      OP_LUI: pd.dst = rt;
      OP_COP0: begin
        pd.is_serial = 1'b1;
        if (rs == COP0_MF)      pd.dst  = rt;
        else if (rs == COP0_MT) pd.src2 = rt;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        pd.is_mem = 1'b1;
        pd.src1   = rs;
        pd.dst    = rt;
      end
      OP_LWL, OP_LWR: begin
        // Partial-word loads merge into the old rt value, so rt is also read
        pd.is_mem = 1'b1;
        pd.src1   = rs;
        pd.src2   = rt;
        pd.dst    = rt;
      end
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: begin
        pd.is_mem = 1'b1;
        pd.src1   = rs;
        pd.src2   = rt;
      end
      default: ;
    endcase
    // Canonical NOP moves no registers at all
    if (instr == 32'h0) begin
      pd.src1 = 5'd0;
      pd.src2 = 5'd0;
      pd.dst  = 5'd0;
    end
  end

endmodule

// File: rtl/decode_issue_queue.sv
// Circular instruction buffer between fetch and decode. Accepts up to FETCH_W
// instructions per cycle, presents up to ISSUE_W head entries per cycle and
// decides how many may issue together under the dual-issue pairing rules.
module decode_issue_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [$clog2(FETCH_W):0]   in_count,
  input  logic [FETCH_W*32-1:0]      in_pc,
  input  logic [FETCH_W*32-1:0]      in_instr,
  input  logic [FETCH_W-1:0]         in_exc,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic [ISSUE_W-1:0]         out_valid,
  output logic [ISSUE_W*32-1:0]      out_pc,
  output logic [ISSUE_W*32-1:0]      out_instr,
  output logic [ISSUE_W-1:0]         out_exc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  iq_entry_t        mem_q [DEPTH];
  iq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Two candidate slots are always read; slot 1 is simply unused when ISSUE_W=1
  iq_entry_t  slot_e  [2];
  predecode_t slot_pd [2];
  logic [1:0] issue_n;
  logic [1:0] pop_n;
  logic       pair_ok;
  logic       push;

  genvar gi;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot_rd
      assign slot_e[gi] = mem_q[PTR_W'(head_q + PTR_W'(gi))];
    end

    for (gi = 0; gi < ISSUE_W; gi++) begin : g_predecode
      instr_predecode u_predecode (
        .instr (slot_e[gi].instr),
        .pd    (slot_pd[gi])
      );
    end

    if (ISSUE_W < 2) begin : g_no_slot1
      assign slot_pd[1] = '0;
    end

    for (gi = 0; gi < ISSUE_W; gi++) begin : g_out
      assign out_valid[gi]          = (issue_n > 2'(gi));
      assign out_pc[gi*32 +: 32]    = slot_e[gi].pc;
      assign out_instr[gi*32 +: 32] = slot_e[gi].instr;
      assign out_exc[gi]            = slot_e[gi].exc;
    end
  endgenerate

  // Ready depends on registered occupancy only, so a same-cycle pop never widens it
  assign in_ready = (count_q <= CNT_W'(DEPTH - FETCH_W));
  assign count    = count_q;

  // Issue count: branch holds for its delay slot, then pairing restrictions on slot 1
  always_comb begin
    issue_n = 2'd0;
    pair_ok = 1'b0;
    if (count_q != '0) begin
      if (ISSUE_W == 2) begin
        if (count_q < CNT_W'(2)) begin
          issue_n = slot_pd[0].is_branch ? 2'd0 : 2'd1;
        end else begin
          pair_ok = !slot_e[0].exc && !slot_e[1].exc && !slot_pd[1].is_branch &&
                    !slot_pd[0].is_serial && !slot_pd[1].is_serial;
          // A branch always takes its delay slot, regardless of hazards on it
          if (!slot_pd[0].is_branch) begin
            if (slot_pd[0].is_mem && slot_pd[1].is_mem)
              pair_ok = 1'b0;
            if (slot_pd[0].dst != 5'd0 &&
                (slot_pd[1].src1 == slot_pd[0].dst || slot_pd[1].src2 == slot_pd[0].dst))
              pair_ok = 1'b0;
          end
          issue_n = pair_ok ? 2'd2 : 2'd1;
        end
      end else begin
        issue_n = 2'd1;
      end
    end
  end

  // Next-state: flush wins, otherwise pop from head and append the fetch group at tail
  always_comb begin
    push    = in_valid && in_ready;
    pop_n   = out_ready ? issue_n : 2'd0;
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d = PTR_W'(head_q + PTR_W'(pop_n));
      if (push) begin
        for (int i = 0; i < FETCH_W; i++) begin
          if (i < int'(in_count)) begin
            mem_d[PTR_W'(tail_q + PTR_W'(i))] = '{pc:    in_pc[i*32 +: 32],
                                                  instr: in_instr[i*32 +: 32],
                                                  exc:   in_exc[i]};
          end
        end
        tail_d = PTR_W'(tail_q + PTR_W'(in_count));
      end
      count_d = count_q + (push ? CNT_W'(in_count) : CNT_W'(0)) - CNT_W'(pop_n);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: directed scenarios plus randomized traffic
// checked against a queue-based model that knows each instruction's meaning.
module tb_decode_issue_queue;

  localparam int DEPTH   = 8;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [1:0]  in_count;
  logic [63:0] in_pc;
  logic [63:0] in_instr;
  logic [1:0]  in_exc;
  logic        in_ready;
  logic        out_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_instr;
  logic [1:0]  out_exc;
  logic [3:0]  count;

  int passed = 0;
  int total  = 0;

  decode_issue_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_exc    (in_exc),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_exc   (out_exc),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  typedef enum int {
    K_ADDU, K_ADDIU, K_LUI, K_SLL, K_LW, K_SW, K_BEQ, K_BGEZAL,
    K_J, K_JAL, K_JR, K_MULT, K_MFLO, K_SYSCALL, K_NOP
  } kind_e;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    kind_e       kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ment_t;

  ment_t mq[$];

  function automatic logic m_branch(ment_t e);
    return e.kind inside {K_BEQ, K_BGEZAL, K_J, K_JAL, K_JR};
  endfunction

  function automatic logic m_mem(ment_t e);
    return e.kind inside {K_LW, K_SW};
  endfunction

  function automatic logic m_serial(ment_t e);
    return e.kind inside {K_MULT, K_MFLO, K_SYSCALL};
  endfunction

  function automatic logic [4:0] m_dst(ment_t e);
    case (e.kind)
      K_ADDU, K_SLL, K_MFLO: return e.rd;
      K_ADDIU, K_LUI, K_LW:  return e.rt;
      K_BGEZAL, K_JAL:       return 5'd31;
      default:               return 5'd0;
    endcase
  endfunction

  function automatic logic m_reads(ment_t e, logic [4:0] r);
    case (e.kind)
      K_ADDU, K_SW, K_BEQ, K_MULT:    return (r == e.rs) || (r == e.rt);
      K_ADDIU, K_LW, K_BGEZAL, K_JR:  return (r == e.rs);
      K_SLL:                          return (r == e.rt);
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic int m_issue();
    ment_t a, b;
    if (mq.size() == 0) return 0;
    a = mq[0];
    if (mq.size() < 2) return m_branch(a) ? 0 : 1;
    b = mq[1];
    if (a.exc || b.exc || m_branch(b)) return 1;
    if (m_serial(a) || m_serial(b)) return 1;
    if (m_branch(a)) return 2;
    if (m_mem(a) && m_mem(b)) return 1;
    if (m_dst(a) != 5'd0 && m_reads(b, m_dst(a))) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic ment_t rand_entry(logic [31:0] pc, logic exc);
    ment_t      e;
    logic [4:0] pool [4];
    logic [15:0] imm;
    pool   = '{5'd0, 5'd1, 5'd2, 5'd31};
    imm    = 16'($urandom());
    e.pc   = pc;
    e.exc  = exc;
    e.kind = kind_e'($urandom_range(0, 14));
    e.rs   = pool[$urandom_range(0, 3)];
    e.rt   = pool[$urandom_range(0, 3)];
    e.rd   = pool[$urandom_range(0, 3)];
    case (e.kind)
      K_ADDU:    begin e.instr = enc_r(e.rs, e.rt, e.rd, 6'h21); end
      K_ADDIU:   begin e.rd = 0; e.instr = enc_i(6'h09, e.rs, e.rt, imm); end
      K_LUI:     begin e.rs = 0; e.rd = 0; e.instr = enc_i(6'h0f, 5'd0, e.rt, imm); end
      K_SLL:     begin e.rs = 0; e.instr = {6'h00, 5'd0, e.rt, e.rd, imm[4:0], 6'h00}; end
      K_LW:      begin e.rd = 0; e.instr = enc_i(6'h23, e.rs, e.rt, imm); end
      K_SW:      begin e.rd = 0; e.instr = enc_i(6'h2b, e.rs, e.rt, imm); end
      K_BEQ:     begin e.rd = 0; e.instr = enc_i(6'h04, e.rs, e.rt, imm); end
      K_BGEZAL:  begin e.rt = 0; e.rd = 0; e.instr = enc_i(6'h01, e.rs, 5'h11, imm); end
      K_J:       begin e.rs = 0; e.rt = 0; e.rd = 0; e.instr = {6'h02, 26'($urandom())}; end
      K_JAL:     begin e.rs = 0; e.rt = 0; e.rd = 0; e.instr = {6'h03, 26'($urandom())}; end
      K_JR:      begin e.rt = 0; e.rd = 0; e.instr = enc_r(e.rs, 5'd0, 5'd0, 6'h08); end
      K_MULT:    begin e.rd = 0; e.instr = enc_r(e.rs, e.rt, 5'd0, 6'h18); end
      K_MFLO:    begin e.rs = 0; e.rt = 0; e.instr = enc_r(5'd0, 5'd0, e.rd, 6'h12); end
      K_SYSCALL: begin e.rs = 0; e.rt = 0; e.rd = 0; e.instr = 32'h0000_000c; end
      default:   begin e.rs = 0; e.rt = 0; e.rd = 0; e.instr = 32'h0; end
    endcase
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_count  = 2'd1;
    in_pc     = '0;
    in_instr  = '0;
    in_exc    = '0;
    out_ready = 1'b0;
  endtask

  task automatic set_lane(int l, logic [31:0] pc, logic [31:0] ins, logic exc);
    in_pc[l*32 +: 32]    = pc;
    in_instr[l*32 +: 32] = ins;
    in_exc[l]            = exc;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    total++; if (out_valid !== 2'b00) $display("FAIL reset_out_valid got=%b exp=00", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    // Reset must act without waiting for a clock edge
    in_valid = 1'b1; in_count = 2'd2;
    set_lane(0, 32'h0000_0100, enc_r(1, 2, 3, 6'h21), 1'b0);
    set_lane(1, 32'h0000_0104, enc_r(1, 2, 4, 6'h21), 1'b0);
    tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++; if (count !== 4'd0 || out_valid !== 2'b00) $display("FAIL async_reset count=%0d valid=%b exp 0/00", count, out_valid); else passed++;
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_dual_issue();
    do_flush();
    in_valid = 1'b1; in_count = 2'd2; out_ready = 1'b1;
    set_lane(0, 32'h1000, enc_r(1, 2, 3, 6'h21), 1'b0);
    set_lane(1, 32'h1004, enc_r(4, 4, 5, 6'h21), 1'b0);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 2'b11) $display("FAIL dual_valid got=%b exp=11", out_valid); else passed++;
    total++; if (out_pc !== {32'h1004, 32'h1000}) $display("FAIL dual_pcs got=%h exp=%h", out_pc, {32'h1004, 32'h1000}); else passed++;
    total++; if (count !== 4'd2) $display("FAIL dual_count_before got=%0d exp=2", count); else passed++;
    tick();
    total++; if (count !== 4'd0 || out_valid !== 2'b00) $display("FAIL dual_drained count=%0d valid=%b exp 0/00", count, out_valid); else passed++;
    $display("test_dual_issue done");
  endtask

  task automatic test_raw();
    do_flush();
    in_valid = 1'b1; in_count = 2'd2; out_ready = 1'b1;
    set_lane(0, 32'h2000, enc_i(6'h09, 0, 4, 16'd1), 1'b0);
    set_lane(1, 32'h2004, enc_r(4, 4, 6, 6'h21), 1'b0);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 2'b01 || out_pc[31:0] !== 32'h2000) $display("FAIL raw_cycle1 valid=%b pc=%h exp 01/2000", out_valid, out_pc[31:0]); else passed++;
    tick();
    total++; if (out_valid !== 2'b01 || out_pc[31:0] !== 32'h2004) $display("FAIL raw_cycle2 valid=%b pc=%h exp 01/2004", out_valid, out_pc[31:0]); else passed++;
    tick();
    total++; if (count !== 4'd0) $display("FAIL raw_drained got=%0d exp=0", count); else passed++;
    $display("test_raw done");
  endtask

  task automatic test_branch_hold();
    do_flush();
    in_valid = 1'b1; in_count = 2'd1; out_ready = 1'b1;
    set_lane(0, 32'h3000, enc_i(6'h04, 1, 2, 16'h0004), 1'b0);
    tick();
    set_lane(0, 32'h3004, enc_r(1, 2, 3, 6'h21), 1'b0);
    total++; if (out_valid !== 2'b00 || count !== 4'd1) $display("FAIL branch_hold valid=%b count=%0d exp 00/1", out_valid, count); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 2'b11 || out_pc !== {32'h3004, 32'h3000}) $display("FAIL branch_pair valid=%b pcs=%h exp 11/%h", out_valid, out_pc, {32'h3004, 32'h3000}); else passed++;
    tick();
    total++; if (count !== 4'd0) $display("FAIL branch_drained got=%0d exp=0", count); else passed++;
    $display("test_branch_hold done");
  endtask

  task automatic test_fill_wrap();
    int nxt;
    do_flush();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_count = 2'd2;
      set_lane(0, 32'h4000 + 32'(8*k),     enc_r(1, 2, 5'(8+2*k), 6'h21), 1'b0);
      set_lane(1, 32'h4000 + 32'(8*k + 4), enc_r(1, 2, 5'(9+2*k), 6'h21), 1'b0);
      tick();
    end
    total++; if (count !== 4'd6 || in_ready !== 1'b1) $display("FAIL fill_six count=%0d ready=%b exp 6/1", count, in_ready); else passed++;
    in_count = 2'd1;
    set_lane(0, 32'h4018, enc_r(1, 2, 14, 6'h21), 1'b0);
    tick();
    total++; if (count !== 4'd7 || in_ready !== 1'b0) $display("FAIL fill_seven count=%0d ready=%b exp 7/0", count, in_ready); else passed++;
    in_count = 2'd2;
    set_lane(0, 32'hdead_0000, enc_r(1, 2, 20, 6'h21), 1'b0);
    set_lane(1, 32'hdead_0004, enc_r(1, 2, 21, 6'h21), 1'b0);
    tick();
    in_valid = 1'b0;
    total++; if (count !== 4'd7) $display("FAIL fill_ignored got=%0d exp=7", count); else passed++;
    out_ready = 1'b1;
    total++; if (out_valid !== 2'b11 || out_pc !== {32'h4004, 32'h4000}) $display("FAIL fill_drain2 valid=%b pcs=%h exp 11/%h", out_valid, out_pc, {32'h4004, 32'h4000}); else passed++;
    tick();
    out_ready = 1'b0;
    total++; if (count !== 4'd5 || in_ready !== 1'b1) $display("FAIL fill_after_drain count=%0d ready=%b exp 5/1", count, in_ready); else passed++;
    in_valid = 1'b1; in_count = 2'd2;
    set_lane(0, 32'h401c, enc_r(1, 2, 15, 6'h21), 1'b0);
    set_lane(1, 32'h4020, enc_r(1, 2, 16, 6'h21), 1'b0);
    tick();
    in_valid = 1'b0;
    total++; if (count !== 4'd7) $display("FAIL fill_refill got=%0d exp=7", count); else passed++;
    out_ready = 1'b1;
    nxt = 2;
    for (int c = 0; c < 6 && nxt <= 8; c++) begin
      if (nxt < 8) begin
        total++;
        if (out_valid !== 2'b11 || out_pc !== {32'h4000 + 32'(4*(nxt+1)), 32'h4000 + 32'(4*nxt)})
          $display("FAIL wrap_order idx=%0d valid=%b pcs=%h exp 11/%h", nxt, out_valid, out_pc,
                   {32'h4000 + 32'(4*(nxt+1)), 32'h4000 + 32'(4*nxt)});
        else passed++;
        nxt += 2;
      end else begin
        total++;
        if (out_valid !== 2'b01 || out_pc[31:0] !== 32'h4020)
          $display("FAIL wrap_last valid=%b pc=%h exp 01/4020", out_valid, out_pc[31:0]);
        else passed++;
        nxt += 1;
      end
      tick();
    end
    total++; if (count !== 4'd0) $display("FAIL wrap_drained got=%0d exp=0", count); else passed++;
    $display("test_fill_wrap done");
  endtask

  task automatic test_flush();
    do_flush();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_count = (k == 2) ? 2'd1 : 2'd2;
      set_lane(0, 32'h6000 + 32'(8*k),     enc_r(1, 2, 3, 6'h21), 1'b0);
      set_lane(1, 32'h6000 + 32'(8*k + 4), enc_r(1, 2, 4, 6'h21), 1'b0);
      tick();
    end
    total++; if (count !== 4'd5) $display("FAIL flush_pre got=%0d exp=5", count); else passed++;
    flush = 1'b1; in_valid = 1'b1; in_count = 2'd2; out_ready = 1'b1;
    set_lane(0, 32'h7000, enc_r(1, 2, 3, 6'h21), 1'b0);
    set_lane(1, 32'h7004, enc_r(1, 2, 4, 6'h21), 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total++; if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) $display("FAIL flush_now count=%0d valid=%b ready=%b exp 0/00/1", count, out_valid, in_ready); else passed++;
    tick();
    total++; if (count !== 4'd0) $display("FAIL flush_push_dropped got=%0d exp=0", count); else passed++;
    in_valid = 1'b1; in_count = 2'd1;
    set_lane(0, 32'h8000, enc_r(1, 2, 3, 6'h21), 1'b0);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 2'b01 || out_pc[31:0] !== 32'h8000) $display("FAIL flush_restart valid=%b pc=%h exp 01/8000", out_valid, out_pc[31:0]); else passed++;
    out_ready = 1'b1;
    tick();
    $display("test_flush done");
  endtask

  task automatic test_exc();
    do_flush();
    in_valid = 1'b1; in_count = 2'd2; out_ready = 1'b1;
    set_lane(0, 32'h5000, enc_i(6'h23, 1, 8, 16'd0), 1'b1);
    set_lane(1, 32'h5004, enc_i(6'h23, 1, 9, 16'd4), 1'b0);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 2'b01 || out_exc[0] !== 1'b1 || out_pc[31:0] !== 32'h5000) $display("FAIL exc_head valid=%b exc=%b pc=%h exp 01/1/5000", out_valid, out_exc[0], out_pc[31:0]); else passed++;
    tick();
    total++; if (out_valid !== 2'b01 || out_exc[0] !== 1'b0 || out_pc[31:0] !== 32'h5004) $display("FAIL exc_next valid=%b exc=%b pc=%h exp 01/0/5004", out_valid, out_exc[0], out_pc[31:0]); else passed++;
    tick();
    total++; if (count !== 4'd0) $display("FAIL exc_drained got=%0d exp=0", count); else passed++;
    $display("test_exc done");
  endtask

  task automatic test_random();
    ment_t       ent [FETCH_W];
    int          exp_n;
    logic [1:0]  exp_valid;
    logic        accept;
    int          rdy_pct;
    logic [31:0] next_pc;
    do_flush();
    mq.delete();
    next_pc = 32'h0010_0000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_n     = m_issue();
      exp_valid = (exp_n == 2) ? 2'b11 : (exp_n == 1) ? 2'b01 : 2'b00;
      total++; if (count !== 4'(mq.size())) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size()); else passed++;
      total++; if (in_ready !== (mq.size() <= DEPTH - FETCH_W)) $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (mq.size() <= DEPTH - FETCH_W)); else passed++;
      total++; if (out_valid !== exp_valid) $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); else passed++;
      for (int s = 0; s < exp_n; s++) begin
        total++;
        if ({out_pc[s*32 +: 32], out_instr[s*32 +: 32], out_exc[s]} !== {mq[s].pc, mq[s].instr, mq[s].exc})
          $display("FAIL rnd_slot%0d cyc=%0d got=%h/%h/%b exp=%h/%h/%b", s, cyc,
                   out_pc[s*32 +: 32], out_instr[s*32 +: 32], out_exc[s], mq[s].pc, mq[s].instr, mq[s].exc);
        else passed++;
      end
      rdy_pct   = ((cyc / 100) % 2 == 1) ? 85 : 35;
      flush     = ($urandom_range(0, 99) < 3);
      in_valid  = ($urandom_range(0, 99) < 65);
      in_count  = 2'($urandom_range(1, FETCH_W));
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      for (int l = 0; l < FETCH_W; l++) begin
        ent[l] = rand_entry(next_pc + 32'(4*l), ($urandom_range(0, 99) < 8));
        set_lane(l, ent[l].pc, ent[l].instr, ent[l].exc);
      end
      next_pc += 32'(4*FETCH_W);
      accept = in_valid && (mq.size() <= DEPTH - FETCH_W);
      if (flush) begin
        mq.delete();
      end else begin
        if (out_ready) repeat (exp_n) void'(mq.pop_front());
        if (accept) for (int l = 0; l < int'(in_count); l++) mq.push_back(ent[l]);
      end
      tick();
    end
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_dual_issue();
    test_raw();
    test_branch_hold();
    test_fill_wrap();
    test_flush();
    test_exc();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
